iic_burst_ctrl: RTL

Multi-byte transaction sequencer sitting directly upstream of `iic_func_module`. It replaces hand-coded single-byte start/done sequences with one burst request. It breaks a burst of up to 8 bytes into byte-wise `iic_func_module` write or read operations. It inserts the EEPROM write-cycle delay after every written byte and streams read bytes back to the requester.

---
 rtl/iic_burst_ctrl_pkg.sv | 17 +
 rtl/iic_delay_cnt.sv | 30 +++
 rtl/iic_burst_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/iic_burst_ctrl_pkg.sv
// Shared opcodes, burst limit and sequencer state encoding
// for the IIC burst controller.
package iic_burst_ctrl_pkg;

  localparam logic [1:0] IIC_OP_WR = 2'b01;
  localparam logic [1:0] IIC_OP_RD = 2'b10;
  localparam int IIC_MAX_BURST = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_WR_WAIT,
    S_FINISH
  } state_t;

endpackage

// File: rtl/iic_delay_cnt.sv
// Generic cycle counter: cleared by load, advances while run,
// expired flags the N-th cycle of a run.
module iic_delay_cnt #(
  parameter int N = 2
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt;

  assign expired = run && (cnt == CW'(N - 1));

  // count cycles of the current run, saturating at expiry
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iic_burst_ctrl.sv
// Burst sequencer: splits an up-to-8-byte request into
// byte-wise iic_func_module operations.
module iic_burst_ctrl
  import iic_burst_ctrl_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int WR_WAIT = 250000,
  parameter int TIMEOUT = 1000000
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [1:0]       Req_Sig,
  input  logic [7:0]       Base_Addr,
  input  logic [LEN_W-1:0] Len,
  input  logic             Load_En,
  input  logic [2:0]       Load_Idx,
  input  logic [7:0]       Load_Data,
  output logic             Busy,
  output logic             Done_Sig,
  output logic             Err,
  output logic             Rd_Valid,
  output logic [2:0]       Rd_Idx,
  output logic [7:0]       Rd_Data,
  output logic [1:0]       I_Start,
  output logic [7:0]       I_Addr,
  output logic [7:0]       I_WrData,
  input  logic [7:0]       I_RdData,
  input  logic             I_Done
);

  state_t state;
  state_t nxt;

  logic [1:0]       op_q;
  logic [7:0]       base_q;
  logic [3:0]       len_q;
  logic [3:0]       cnt_q;
  logic             abort_q;
  logic [7:0]       buf_q [IIC_MAX_BURST];
  logic [LEN_W-1:0] len_c;
  logic             accept;
  logic             in_issue;
  logic             in_wait;
  logic             to_exp;
  logic             ww_exp;

  assign len_c = (Len > LEN_W'(IIC_MAX_BURST))
               ? LEN_W'(IIC_MAX_BURST) : Len;

  assign accept = (state == S_IDLE)
               && ((Req_Sig == IIC_OP_WR)
               ||  (Req_Sig == IIC_OP_RD));

  assign in_issue = (state == S_ISSUE);
  assign in_wait  = (state == S_WR_WAIT);

  assign Busy     = (state != S_IDLE);
  assign I_Start  = in_issue ? op_q : 2'b00;
  assign I_Addr   = in_issue ? base_q + {4'b0, cnt_q} : 8'h00;
  assign I_WrData = in_issue ? buf_q[cnt_q[2:0]] : 8'h00;

  iic_delay_cnt #(.N(WR_WAIT)) u_wr_wait (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .load    (!in_wait),
    .run     (in_wait),
    .expired (ww_exp)
  );

  iic_delay_cnt #(.N(TIMEOUT)) u_timeout (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .load    (!in_issue),
    .run     (in_issue),
    .expired (to_exp)
  );

  // state register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next-state logic; I_Done wins over a same-cycle timeout
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          nxt = (len_c == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (I_Done) begin
          nxt = (op_q == IIC_OP_RD) ? S_GAP : S_WR_WAIT;
        end else if (to_exp) begin
          nxt = S_FINISH;
        end
      end
      S_WR_WAIT: begin
        if (ww_exp) begin
          nxt = S_GAP;
        end
      end
      S_GAP: begin
        nxt = (cnt_q + 4'd1 == len_q) ? S_FINISH : S_ISSUE;
      end
      S_FINISH: begin
        nxt = S_IDLE;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

  // burst context, byte counter and abort flag
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      op_q    <= 2'b00;
      base_q  <= 8'h00;
      len_q   <= 4'd0;
      cnt_q   <= 4'd0;
      abort_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= Req_Sig;
        base_q <= Base_Addr;
        len_q  <= len_c[3:0];
        cnt_q  <= 4'd0;
      end
      if (state == S_GAP) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (in_issue && !I_Done && to_exp) begin
        abort_q <= 1'b1;
      end else if (state == S_FINISH) begin
        abort_q <= 1'b0;
      end
    end
  end

  // registered completion and read-byte pulses
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Done_Sig <= 1'b0;
      Err      <= 1'b0;
      Rd_Valid <= 1'b0;
      Rd_Idx   <= 3'd0;
      Rd_Data  <= 8'h00;
    end else begin
      Done_Sig <= (state == S_FINISH);
      Err      <= (state == S_FINISH) && abort_q;
      Rd_Valid <= in_issue && I_Done && (op_q == IIC_OP_RD);
      if (in_issue && I_Done && (op_q == IIC_OP_RD)) begin
        Rd_Idx  <= cnt_q[2:0];
        Rd_Data <= I_RdData;
      end
    end
  end

  // write buffer, frozen while a burst runs
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < IIC_MAX_BURST; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else if (Load_En && !Busy) begin
      buf_q[Load_Idx] <= Load_Data;
    end
  end

endmodule
